// File: rtl/led_blink_sequencer_pkg.sv
// led_blink_sequencer_pkg: shared state encoding, 25 MHz default periods and timer width helper
package led_blink_sequencer_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;
  localparam int DEF_CLKS_PER_ON  = 12500000;
  localparam int DEF_CLKS_PER_OFF = 12500000;
  function automatic int timer_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction
endpackage

// File: rtl/led_blink_sequencer_cycle_timer.sv
// cycle_timer: down-counter (clk, rst, clr_i, load_i, load_val_i -> expired_o when count is 0), holds at 0
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : load_i ? load_val_i : cnt_q - W'(cnt_q != '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired_o = cnt_q == '0;
endmodule

// File: rtl/led_blink_sequencer.sv
// led_blink_sequencer: blinks o_LED i_Count times on i_Start (i_Abort cancels), reports o_Ready/o_Busy/o_Done
module led_blink_sequencer
  import led_blink_sequencer_pkg::*;
#(
  parameter int CLKS_PER_ON  = DEF_CLKS_PER_ON,
  parameter int CLKS_PER_OFF = DEF_CLKS_PER_OFF,
  parameter int COUNT_WIDTH  = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Start,
  input  logic [COUNT_WIDTH-1:0] i_Count,
  input  logic                   i_Abort,
  output logic                   o_Ready,
  output logic                   o_LED,
  output logic                   o_Busy,
  output logic                   o_Done
);
  localparam int TW = timer_width(CLKS_PER_ON, CLKS_PER_OFF);
  localparam logic [TW-1:0] ON_LD  = TW'(CLKS_PER_ON - 1);
  localparam logic [TW-1:0] OFF_LD = TW'(CLKS_PER_OFF - 1);
  state_t state_q, state_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d, rem_dec;
  logic led_q, busy_q, done_q, done_d, load, expired;
  logic [TW-1:0] load_val;
  assign rem_dec = (rem_q != '0) ? rem_q - 1'b1 : rem_q;
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    load     = 1'b0;
    load_val = ON_LD;
    case (state_q)
      IDLE:
        if (i_Start && !i_Abort) begin
          rem_d = i_Count;
          if (i_Count == '0) done_d = 1'b1;
          else begin
            state_d = ON;
            load    = 1'b1;
          end
        end
      ON:
        if (i_Abort) begin
          state_d = IDLE;
          rem_d   = '0;
        end else if (expired) begin
          state_d  = OFF;
          load     = 1'b1;
          load_val = OFF_LD;
        end
      OFF:
        if (i_Abort) begin
          state_d = IDLE;
          rem_d   = '0;
        end else if (expired) begin
          rem_d = rem_dec;
          if (rem_dec != '0) begin
            state_d = ON;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      led_q   <= state_d == ON;
      busy_q  <= state_d != IDLE;
      done_q  <= done_d;
    end
  cycle_timer #(.W(TW)) u_timer (
    .clk       (i_Clk),
    .rst       (i_Reset),
    .clr_i     (state_d == IDLE),
    .load_i    (load),
    .load_val_i(load_val),
    .expired_o (expired)
  );
  assign o_LED   = led_q;
  assign o_Busy  = busy_q;
  assign o_Ready = ~busy_q;
  assign o_Done  = done_q;
endmodule

// File: tb/tb_led_blink_sequencer.sv
// tb_led_blink_sequencer: directed and random stimulus checked against a cycle-index reference model
module tb_led_blink_sequencer;
  localparam int ON = 3;
  localparam int OFF = 2;
  localparam int P = ON + OFF;
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [3:0] count = 0;
  logic ready, led, busy, done;
  int tests = 0, fails = 0;
  bit m_active = 0, m_done = 0;
  int m_n = 0, m_t = 0;
  led_blink_sequencer #(.CLKS_PER_ON(ON), .CLKS_PER_OFF(OFF), .COUNT_WIDTH(4)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Count(count), .i_Abort(abort),
    .o_Ready(ready), .o_LED(led), .o_Busy(busy), .o_Done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_edge(input bit s, input int c, input bit a);
    m_done = 0;
    if (m_active) begin
      if (a) m_active = 0;
      else if (m_t == m_n * P) begin
        m_active = 0;
        m_done = 1;
      end else m_t++;
    end else if (s && !a) begin
      if (c == 0) m_done = 1;
      else begin
        m_active = 1;
        m_n = c;
        m_t = 1;
      end
    end
  endtask
  task automatic check_all();
    check("led", led, int'(m_active && ((m_t - 1) % P) < ON));
    check("busy", busy, int'(m_active));
    check("ready", ready, int'(!m_active));
    check("done", done, int'(m_done));
  endtask
  task automatic step(input bit s, input int c, input bit a);
    start = s;
    count = 4'(c);
    abort = a;
    @(posedge clk);
    model_edge(s, c, a);
    #1;
    check_all();
    start = 0;
    abort = 0;
  endtask
  initial begin
    int rises, bcycles, dones;
    bit prev;
    #12 rst = 0;
    #1;
    check_all();
    step(1, 2, 0);
    repeat (12) step(0, 0, 0);
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    repeat (4) step(0, 0, 0);
    check("done_cycle", done, 1);
    step(1, 1, 0);
    repeat (7) step(0, 0, 0);
    step(1, 3, 0);
    repeat (5) step(0, 0, 0);
    check("second_on", led, 1);
    step(0, 0, 1);
    step(1, 5, 1);
    repeat (3) step(0, 0, 0);
    step(1, 15, 0);
    rises = 1;
    bcycles = 1;
    dones = 0;
    prev = led;
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0);
      rises += int'(led && !prev);
      bcycles += int'(busy);
      dones += int'(done);
      prev = led;
    end
    check("rises15", rises, 15);
    check("busy75", bcycles, 75);
    check("done15", dones, 1);
    step(1, 5, 0);
    repeat (2) step(0, 0, 0);
    check("pre_reset_led", led, 1);
    #2 rst = 1;
    #1;
    check("async_led", led, 0);
    check("async_busy", busy, 0);
    check("async_ready", ready, 1);
    check("async_done", done, 0);
    @(posedge clk);
    #2 rst = 0;
    m_active = 0;
    m_done = 0;
    repeat (3) step(0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 15),
           $urandom_range(0, 63) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/led_blink_sequencer.md
Name: led_blink_sequencer

Overview:
- Output-side counterpart to the switch-input toggle logic. The switch block turns user input into fabric state; this block turns a fabric request into a visible LED pattern for the user.
- On a start request it blinks the LED a requested number of times, with programmable on and off periods, then pulses done.
- Used to report counts and status codes on the board LEDs.

Parameters:
- CLKS_PER_ON, 12500000, clock cycles the LED is lit per blink (0.5 s at 25 MHz). Must be at least 1.
- CLKS_PER_OFF, 12500000, clock cycles the LED is dark after each blink. Must be at least 1.
- COUNT_WIDTH, 4, width of the blink-count request.

Ports:
- i_Clk  input  1  system clock; all logic is on the rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Start  input  1  request strobe; accepted only when o_Ready=1.
- i_Count  input  COUNT_WIDTH  number of blinks; sampled on the accepting edge.
- i_Abort  input  1  cancel any sequence in progress.
- o_Ready  output  1  high when a start will be accepted.
- o_LED  output  1  LED drive, registered, active high.
- o_Busy  output  1  high while a sequence is in progress.
- o_Done  output  1  one-cycle pulse when a sequence completes normally.

Behaviour:
- Interface: one clock, i_Clk. i_Reset is asynchronous and active-high.
- Reset values: state=IDLE, o_LED=0, o_Busy=0, o_Done=0, o_Ready=1, timer=0, remaining=0. Reset takes effect immediately, without waiting for a clock edge, including mid-blink.
- States:
  - IDLE: o_Ready=1, o_LED=0.
  - ON: o_LED=1.
  - OFF: o_LED=0.
- o_Busy is 1 in ON and OFF; o_Ready = ~o_Busy.
- Accept: a start is accepted on a rising edge where i_Start=1, o_Ready=1 and i_Abort=0. The edge latches i_Count into remaining.
- Accept with i_Count=0: no blink, state stays IDLE, o_Done=1 for the next cycle only.
- Accept with i_Count=N>0: state goes to ON, so o_LED=1 from the cycle after the accepting edge.
- ON lasts exactly CLKS_PER_ON cycles, then OFF lasts exactly CLKS_PER_OFF cycles.
- At the end of each OFF period, remaining is decremented.
  - If the new value is nonzero: go to ON.
  - If it is zero: go to IDLE, and o_Done=1 for exactly that first IDLE cycle.
- Total busy time is N*(CLKS_PER_ON+CLKS_PER_OFF) cycles. o_LED is high for exactly N*CLKS_PER_ON cycles.
- Back-to-back: o_Ready=1 in the same cycle as o_Done, so a start in that cycle is accepted and o_LED rises on the next cycle.
- i_Start while busy is ignored, with no queuing. Changes on i_Count after acceptance have no effect.
- i_Abort=1 in ON or OFF: on the next edge, state=IDLE, o_LED=0, remaining=0, no o_Done pulse.
- i_Abort=1 in IDLE has no effect, but it blocks a simultaneous i_Start; abort wins.
- Timer:
  - Down-counter, width $clog2 of max(CLKS_PER_ON, CLKS_PER_OFF)+1.
  - Loaded with period-1 on entry to ON or OFF; the state advances when the counter reaches 0.
  - No wrap: the counter is held at 0 outside ON and OFF.
- Maximum count: i_Count all-ones (15 by default) gives 15 blinks. remaining is never decremented below 0.

Decomposition:
- Shared package: state encodings (IDLE=2'd0, ON=2'd1, OFF=2'd2), plus the default period constants for the 25 MHz board clock.
- One sub-module, cycle_timer:
  - Parameterised down-counter with load value and load strobe.
  - Outputs an expired flag when the counter is 0.
  - Async active-high reset to 0.
- The FSM, the remaining counter and the output registers stay in led_blink_sequencer.

Test Plan:
(all runs use CLKS_PER_ON=3, CLKS_PER_OFF=2)
- Reset: hold i_Reset mid-ON with N=5 -> o_LED=0 immediately (asynchronously), o_Ready=1 and o_Busy=0 after release, no o_Done.
- Start with i_Count=2 at edge k -> o_LED high cycles k+1..k+3 and k+6..k+8, low k+4..k+5 and k+9..k+10, o_Done=1 at cycle k+11 only, o_Busy high k+1..k+10.
- Start with i_Count=0 -> o_LED never rises, o_Done=1 on the next cycle, o_Busy stays 0.
- Start with i_Count=1; pulse i_Start again at the o_Done cycle with i_Count=1 -> second blink begins the following cycle. An i_Start during the first blink is ignored (exactly 2 blinks total).
- Start with i_Count=3; assert i_Abort during the 2nd ON -> o_LED=0 the next cycle, no o_Done, o_Ready=1. i_Abort together with i_Start in IDLE -> nothing accepted.
- Start with i_Count=15 -> exactly 15 rising edges on o_LED, busy for 75 cycles, then a single o_Done pulse.
